// File: rtl/vga_pkg.sv
// Shared VGA timing constants, bus widths and the frame-buffer address mapping.
// Default timing is 640x480 @ 60 Hz with a 4:1 system-to-pixel clock ratio.
package vga_pkg;

    localparam int CLK_DIV_DEF = 4;
    localparam int H_VIS_DEF   = 640;
    localparam int H_FP_DEF    = 16;
    localparam int H_SYNC_DEF  = 96;
    localparam int H_BP_DEF    = 48;
    localparam int V_VIS_DEF   = 480;
    localparam int V_FP_DEF    = 10;
    localparam int V_SYNC_DEF  = 2;
    localparam int V_BP_DEF    = 33;

    localparam int H_TOTAL      = H_VIS_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL      = V_VIS_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
    localparam int H_SYNC_START = H_VIS_DEF + H_FP_DEF;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_DEF - 1;
    localparam int V_SYNC_START = V_VIS_DEF + V_FP_DEF;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_DEF - 1;

    localparam int ADDR_W   = 15;
    localparam int COLOUR_W = 8;
    localparam int CNT_W    = 10;

    typedef logic [ADDR_W-1:0]   addr_t;
    typedef logic [COLOUR_W-1:0] colour_t;
    typedef logic [CNT_W-1:0]    cnt_t;

    // {v[8:2], h[9:2]}: each buffer pixel covers a 4x4 block of screen pixels
    function automatic addr_t pixel_addr(cnt_t h, cnt_t v);
        return ({5'd0, v >> 2} << 8) | addr_t'(h >> 2);
    endfunction

endpackage

// File: rtl/vga_counter.sv
// Wrap-around counter 0..MAX with enable; wrap flags the enabled terminal count.
// Used for the pixel divider and for the horizontal and vertical positions.
module vga_counter #(
    parameter int W   = 10,
    parameter int MAX = 799
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         wrap
);

    assign wrap = en && (count == W'(MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (wrap) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/vga_sig_gen.sv
// VGA sync/colour generator reading a 1-bit frame buffer; one pixel period of
// latency from counters to pins, with sync and colour registered together.
module vga_sig_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF,
    parameter int H_VIS   = H_VIS_DEF,
    parameter int H_FP    = H_FP_DEF,
    parameter int H_SYNC  = H_SYNC_DEF,
    parameter int H_BP    = H_BP_DEF,
    parameter int V_VIS   = V_VIS_DEF,
    parameter int V_FP    = V_FP_DEF,
    parameter int V_SYNC  = V_SYNC_DEF,
    parameter int V_BP    = V_BP_DEF
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [15:0]         CONFIG_COLOURS,
    output logic [ADDR_W-1:0]   DPR_ADDR,
    input  logic                DPR_DATA,
    output logic                VGA_HS,
    output logic                VGA_VS,
    output logic [COLOUR_W-1:0] VGA_COLOUR,
    output logic                FRAME_START
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int H_SS  = H_VIS + H_FP;
    localparam int H_SE  = H_SS + H_SYNC;
    localparam int V_SS  = V_VIS + V_FP;
    localparam int V_SE  = V_SS + V_SYNC;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_count_unused;
    logic             pe;
    logic             h_wrap;
    logic             v_wrap;
    cnt_t             h_count;
    cnt_t             v_count;
    cnt_t             h_next;
    cnt_t             v_next;
    logic             de;
    logic             hs_raw;
    logic             vs_raw;

    vga_counter #(.W(DIV_W), .MAX(CLK_DIV - 1)) u_div (
        .clk(CLK), .rst_n(RESET), .en(1'b1), .count(div_count_unused), .wrap(pe)
    );

    vga_counter #(.W(CNT_W), .MAX(H_TOT - 1)) u_hcount (
        .clk(CLK), .rst_n(RESET), .en(pe), .count(h_count), .wrap(h_wrap)
    );

    // h_wrap already includes the pixel enable, so V steps once per line
    vga_counter #(.W(CNT_W), .MAX(V_TOT - 1)) u_vcount (
        .clk(CLK), .rst_n(RESET), .en(h_wrap), .count(v_count), .wrap(v_wrap)
    );

    always_comb begin
        h_next = h_wrap ? '0 : h_count + 1'b1;
        v_next = v_count;
        if (h_wrap) begin
            v_next = v_wrap ? '0 : v_count + 1'b1;
        end
        de     = (h_count < CNT_W'(H_VIS)) && (v_count < CNT_W'(V_VIS));
        hs_raw = !((h_count >= CNT_W'(H_SS)) && (h_count < CNT_W'(H_SE)));
        vs_raw = !((v_count >= CNT_W'(V_SS)) && (v_count < CNT_W'(V_SE)));
    end

    // The address is issued one PE ahead, so DPR_DATA here belongs to h_count/v_count
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            DPR_ADDR    <= '0;
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_COLOUR  <= '0;
            FRAME_START <= 1'b0;
        end else begin
            FRAME_START <= v_wrap;
            if (pe) begin
                DPR_ADDR <= pixel_addr(h_next, v_next);
                VGA_HS   <= hs_raw;
                VGA_VS   <= vs_raw;
                if (!de) begin
                    VGA_COLOUR <= '0;
                end else if (DPR_DATA) begin
                    VGA_COLOUR <= CONFIG_COLOURS[15:8];
                end else begin
                    VGA_COLOUR <= CONFIG_COLOURS[7:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_sig_gen.sv
// Bench for vga_sig_gen at reduced frame size: a pixel-index reference model
// feeds a scoreboard, plus sync/frame interval measurements and reset checks.
module tb_vga_sig_gen;

    localparam int CLK_DIV = 4;
    localparam int H_VIS = 128, H_FP = 8, H_SYNC = 16, H_BP = 8;
    localparam int V_VIS = 16,  V_FP = 3, V_SYNC = 2,  V_BP = 3;
    localparam int H_T = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_T = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int N   = H_T * V_T;
    localparam int MID_PIX = (V_VIS / 2) * H_T + 60;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] colours;
    logic [14:0] dpr_addr;
    logic        dpr_data = 1'b0;
    logic        vga_hs;
    logic        vga_vs;
    logic [7:0]  vga_colour;
    logic        frame_start;

    vga_sig_gen #(
        .CLK_DIV(CLK_DIV), .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) dut (
        .CLK(clk), .RESET(rst_n), .CONFIG_COLOURS(colours), .DPR_ADDR(dpr_addr),
        .DPR_DATA(dpr_data), .VGA_HS(vga_hs), .VGA_VS(vga_vs),
        .VGA_COLOUR(vga_colour), .FRAME_START(frame_start)
    );

    always #5 clk = ~clk;

    bit mem [0:32767];
    always @(posedge clk) dpr_data <= mem[dpr_addr];

    typedef struct {
        logic [14:0] addr;
        logic        hs;
        logic        vs;
        logic [7:0]  colour;
        logic        fs;
    } exp_t;

    exp_t sb_q[$];
    exp_t cur;
    exp_t got;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   t;
    bit   released;
    bit   rand_colours;

    task automatic check(string name, longint act, longint exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
            if (n_checks - n_pass >= 40) begin
                $display("%0d/%0d checks passed", n_pass, n_checks);
                $finish;
            end
        end
    endtask

    function automatic exp_t reset_exp();
        exp_t e;
        e.addr = '0; e.hs = 1'b1; e.vs = 1'b1; e.colour = '0; e.fs = 1'b0;
        return e;
    endfunction

    function automatic logic [14:0] addr_of(int h, int v);
        return 15'((v / 4) * 256 + (h / 4));
    endfunction

    // One system clock: advance the model by absolute pixel index and queue the expectation
    task automatic step();
        int k, c, h, v, nx;
        @(posedge clk);
        if (!released) begin
            cur = reset_exp();
        end else begin
            t++;
            cur.fs = 1'b0;
            if (t % CLK_DIV == 0) begin
                k  = t / CLK_DIV;
                c  = (k - 1) % N;
                h  = c % H_T;
                v  = c / H_T;
                nx = k % N;
                cur.addr = addr_of(nx % H_T, nx / H_T);
                cur.hs   = !(h >= H_VIS + H_FP && h < H_VIS + H_FP + H_SYNC);
                cur.vs   = !(v >= V_VIS + V_FP && v < V_VIS + V_FP + V_SYNC);
                if (h < H_VIS && v < V_VIS)
                    cur.colour = mem[addr_of(h, v)] ? colours[15:8] : colours[7:0];
                else
                    cur.colour = 8'h00;
                cur.fs = (nx == 0);
            end
        end
        sb_q.push_back(cur);
        #1;
        if (rand_colours && $urandom_range(63) == 0) colours = 16'($urandom);
    endtask

    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            got = sb_q.pop_front();
            check("dpr_addr", dpr_addr, got.addr);
            check("vga_hs", vga_hs, got.hs);
            check("vga_vs", vga_vs, got.vs);
            check("vga_colour", vga_colour, got.colour);
            check("frame_start", frame_start, got.fs);
        end else begin
            check("sb_queue_depth", sb_q.size(), 1);
        end
    end

    int since_fs, since_hs_fall, hs_low, vs_low;
    int fs_seen = 0, hs_seen = 0, vs_seen = 0;
    bit hs_prev, vs_prev, hs_fall_seen;

    always @(negedge clk) begin
        if (!rst_n) begin
            since_fs = 0; since_hs_fall = 0; hs_low = 0; vs_low = 0;
            hs_prev = 1'b1; vs_prev = 1'b1; hs_fall_seen = 1'b0;
        end else begin
            since_fs++;
            since_hs_fall++;
            if (frame_start) begin
                check("frame_period", since_fs, CLK_DIV * N);
                fs_seen++;
                since_fs = 0;
            end
            if (!vga_hs) hs_low++;
            if (!vga_vs) vs_low++;
            if (hs_prev && !vga_hs) begin
                if (hs_fall_seen) check("line_period", since_hs_fall, CLK_DIV * H_T);
                else              check("hs_first_fall", since_fs, CLK_DIV * (H_VIS + H_FP + 1));
                hs_fall_seen  = 1'b1;
                since_hs_fall = 0;
            end
            if (!hs_prev && vga_hs) begin
                check("hs_width", hs_low, CLK_DIV * H_SYNC);
                hs_seen++;
                hs_low = 0;
            end
            if (!vs_prev && vga_vs) begin
                check("vs_width", vs_low, CLK_DIV * H_T * V_SYNC);
                vs_seen++;
                vs_low = 0;
            end
            hs_prev = vga_hs;
            vs_prev = vga_vs;
        end
    end

    initial begin
        rst_n        = 1'b0;
        colours      = 16'hE01C;
        released     = 1'b0;
        rand_colours = 1'b0;
        t            = 0;
        cur          = reset_exp();
        for (int i = 0; i < 32768; i++) mem[i] = 1'b0;
        mem[15'h0102] = 1'b1;

        repeat (10) step();
        check("rst_hs", vga_hs, 1);
        check("rst_vs", vga_vs, 1);
        check("rst_colour", vga_colour, 0);
        check("rst_addr", dpr_addr, 0);
        check("rst_frame_start", frame_start, 0);

        @(negedge clk); #1;
        rst_n = 1'b1; released = 1'b1; t = 0;

        // First frame: single lit block at 0x0102 with fixed colours
        repeat (CLK_DIV * (N - H_T)) step();
        for (int i = 0; i < 32768; i++) mem[i] = 1'($urandom);
        rand_colours = 1'b1;
        repeat (CLK_DIV * (N + H_T + MID_PIX)) step();

        // Mid-frame asynchronous reset, checked with no clock edge in between
        @(negedge clk); #1;
        rst_n = 1'b0; released = 1'b0; cur = reset_exp();
        #1;
        check("mid_rst_hs", vga_hs, 1);
        check("mid_rst_vs", vga_vs, 1);
        check("mid_rst_colour", vga_colour, 0);
        check("mid_rst_addr", dpr_addr, 0);
        check("mid_rst_frame_start", frame_start, 0);
        repeat (5) step();

        @(negedge clk); #1;
        rst_n = 1'b1; released = 1'b1; t = 0;
        repeat (CLK_DIV * N + 400) step();

        @(negedge clk); #1;
        check("frame_pulses_seen", fs_seen, 3);
        check("vs_pulses_seen", vs_seen, 3);
        check("hs_pulses_seen", hs_seen, 2 * V_T + V_VIS / 2 + V_T);
        check("sb_leftover", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
